// File: rtl/adder_share_arb.sv
// adder_share_arb: time-shares one external combinational adder among NREQ
// requesters. A round-robin arbiter grants one request at a time and registers
// its operands toward the adder. After ADD_LAT settle cycles the sum and carry
// are captured into a response register, which is held until the consumer
// accepts it.
module adder_share_arb #(
    parameter int N       = 16,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*N-1:0] i_req_a,
    input  logic [NREQ*N-1:0] i_req_b,
    output logic [N-1:0]      o_add_a,
    output logic [N-1:0]      o_add_b,
    input  logic [N-1:0]      i_add_sum,
    input  logic              i_add_cout,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [N-1:0]      o_rsp_sum,
    output logic              o_rsp_cout,
    output logic              o_busy
);

    // Settle counter only has to hold ADD_LAT-1.
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_cnt;
    logic [IDW-1:0]  r_id;
    logic [N-1:0]    r_add_a;
    logic [N-1:0]    r_add_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [N-1:0]    r_rsp_sum;
    logic            r_rsp_cout;

    logic [IDW:0]    w_pick;
    logic            w_found;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_handshake;

    // Round-robin pick: first valid requester at or after ptr, wrapping
    // modulo NREQ. Returns {found, index}. Scanning from the far end down
    // lets the closest valid requester overwrite any later one.
    function automatic logic [IDW:0] f_rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW:0] result;
        int           idx;
        result = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (valid[idx]) result = {1'b1, IDW'(idx)};
        end
        return result;
    endfunction

    // Arbitration decode and grant handshake.
    always_comb begin
        w_pick      = f_rr_pick(i_req_valid, r_rr_ptr);
        w_found     = w_pick[IDW];
        w_gnt_idx   = w_pick[IDW-1:0];
        w_handshake = (r_state == S_IDLE) && w_found && !rst;
        w_ptr_nxt   = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
    end

    // One-hot grant toward the winning requester, only while idle.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional write, so no path leaves it unassigned (no latch).
        o_req_ready = '0;
        if (w_handshake) o_req_ready[w_gnt_idx] = 1'b1;
    end

    // Next-state logic for the grant / settle / respond sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_handshake) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:   if (i_rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand, arbitration-pointer, settle-counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_add_a  <= i_req_a[int'(w_gnt_idx)*N +: N];
                r_add_b  <= i_req_b[int'(w_gnt_idx)*N +: N];
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
                r_cnt    <= CW'(ADD_LAT - 1);
            end
            if (r_state == S_SETTLE) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_rsp_sum   <= i_add_sum;
                    r_rsp_cout  <= i_add_cout;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_cout  = r_rsp_cout;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Testbench for adder_share_arb: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_adder_share_arb;

    localparam int N       = 16;
    localparam int NREQ    = 4;
    localparam int ADD_LAT = 1;
    localparam int IDW     = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [N-1:0]      add_a;
    logic [N-1:0]      add_b;
    logic [N-1:0]      add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    adder_share_arb #(.N(N), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .i_add_cout  (add_cout),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external shared adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one operation in flight, response visible a fixed
    // number of cycles after its grant, held until accepted.
    typedef struct {
        int           id;
        logic [N:0]   res;
    } rsp_t;

    bit          m_busy;
    int          m_due;
    int          m_ptr;
    logic [N-1:0] m_add_a, m_add_b;
    rsp_t        m_pend, m_last;

    int          obs_grants[$];
    logic [N-1:0] obs_sums[$];
    int          obs_ids[$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_due   = 0;
        m_ptr   = 0;
        m_add_a = '0;
        m_add_b = '0;
        m_last  = '{id: 0, res: '0};
        m_pend  = '{id: 0, res: '0};
    endtask

    // One clock cycle: compare outputs against the model, advance the model
    // by what the coming edge does, then move past the edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              rsp_vis;
        logic [N-1:0]    ga, gb;
        #1;
        g       = (!rst && !m_busy) ? rr_pick(req_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rsp_vis = m_busy && (cyc >= m_due);
        if (rsp_vis) m_last = m_pend;

        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, rsp_vis);
        check("busy", busy, m_busy);
        check("add_a", add_a, m_add_a);
        check("add_b", add_b, m_add_b);
        check("rsp_id", rsp_id, m_last.id);
        check("rsp_sum", rsp_sum, m_last.res[N-1:0]);
        check("rsp_cout", rsp_cout, m_last.res[N]);

        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) obs_grants.push_back(i);
        end
        if (rsp_valid && rsp_ready && !rst) begin
            obs_sums.push_back(rsp_sum);
            obs_ids.push_back(int'(rsp_id));
        end

        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            ga         = req_a[g*N +: N];
            gb         = req_b[g*N +: N];
            m_busy     = 1'b1;
            m_due      = cyc + ADD_LAT + 1;
            m_add_a    = ga;
            m_add_b    = gb;
            m_pend.id  = g;
            m_pend.res = {1'b0, ga} + {1'b0, gb};
            m_ptr      = (g + 1) % NREQ;
        end else if (rsp_vis && rsp_ready) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && m_busy; i++) step();
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        // First edge establishes a known state before anything is compared.
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with every request pending: nothing is granted.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        obs_grants.delete();
        step();
        check("reset_first_gnt_cnt", obs_grants.size(), 1);
        if (obs_grants.size() > 0) check("reset_first_gnt", obs_grants[0], 0);
        drain();

        // Single op from requester 2.
        set_op(2, 16'h00FF, 16'h0001);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        check("single_valid", rsp_valid, 1'b1);
        check("single_id", rsp_id, 2);
        check("single_sum", rsp_sum, 16'h0100);
        check("single_cout", rsp_cout, 1'b0);
        drain();

        // Overflow cases.
        set_op(0, 16'hFFFF, 16'h0001);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        check("ovf0_sum", rsp_sum, 16'h0000);
        check("ovf0_cout", rsp_cout, 1'b1);
        drain();
        set_op(1, 16'h8000, 16'h8000);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        check("ovf1_sum", rsp_sum, 16'h0000);
        check("ovf1_cout", rsp_cout, 1'b1);
        drain();

        // Fairness: all requesters held valid from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, N'(i), N'(16 * i));
        req_valid = '1;
        rsp_ready = 1'b1;
        obs_grants.delete();
        obs_sums.delete();
        obs_ids.delete();
        for (int i = 0; i < 18; i++) step();
        check("fair_gnt_cnt", obs_grants.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_grants.size()) check("fair_gnt", obs_grants[i], i % NREQ);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < obs_sums.size()) begin
                check("fair_sum", obs_sums[i], N'(17 * i));
                check("fair_id", obs_ids[i], i);
            end
        end
        drain();

        // Backpressure: response held while requester 1 waits.
        set_op(1, 16'h1234, 16'h1111);
        set_op(2, 16'h0F0F, 16'hF0F1);
        req_valid = 4'b0110;
        obs_grants.delete();
        step();
        req_valid = 4'b0010;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", req_ready, 4'b0000);
            check("bp_busy", busy, 1'b1);
            check("bp_sum", rsp_sum, 16'h0000);
            check("bp_cout", rsp_cout, 1'b1);
        end
        rsp_ready = 1'b1;
        step();
        step();
        check("bp_gnt_cnt", obs_grants.size(), 2);
        if (obs_grants.size() == 2) begin
            check("bp_first_gnt", obs_grants[0], 2);
            check("bp_next_gnt", obs_grants[1], 1);
        end
        drain();

        // Reset during SETTLE aborts the op and returns the pointer to 0.
        set_op(3, 16'hAAAA, 16'h5555);
        req_valid = 4'b1000;
        obs_grants.delete();
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midop_no_rsp", rsp_valid, 1'b0);
        check("midop_busy", busy, 1'b0);
        req_valid = 4'b1010;
        step();
        check("midop_gnt_cnt", obs_grants.size(), 2);
        if (obs_grants.size() == 2) check("midop_next_gnt", obs_grants[1], 1);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
